// File: rtl/dm_defs_pkg.sv
// Shared data-memory definitions: store-width encodings, trace entry
// layout and the byte-lane merge used by the DM responder.
package dm_defs;

  localparam logic [1:0] WLEN_WORD = 2'b00;
  localparam logic [1:0] WLEN_HALF = 2'b01;
  localparam logic [1:0] WLEN_BYTE = 2'b10;
  localparam logic [1:0] WLEN_RSVD = 2'b11;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_ent_t;

  // True when the store width is legal for the given byte offset.
  function automatic logic store_aligned(input logic [1:0] wlen,
                                         input logic [1:0] lane);
    logic ok;
    ok = 1'b0;
    case (wlen)
      WLEN_WORD: ok = (lane == 2'b00);
      WLEN_HALF: ok = ~lane[0];
      WLEN_BYTE: ok = 1'b1;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Merge right-aligned store data into the old word, little-endian lanes.
  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  wlen,
                                             input logic [1:0]  lane);
    logic [31:0] w;
    w = old_w;
    case (wlen)
      WLEN_WORD: w = wdata;
      WLEN_HALF: begin
        if (lane[1]) w[31:16] = wdata[15:0];
        else         w[15:0]  = wdata[15:0];
      end
      WLEN_BYTE: w[{lane, 3'b000} +: 8] = wdata[7:0];
      default:   w = old_w;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dm_responder_trace_fifo.sv
// Trace FIFO: power-of-two depth, extra-MSB pointers, head read straight
// from the storage registers so it holds while not popped.
module trace_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         drop_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q, wr_d, rd_d;
  logic         pop_ok, push_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  // A pop frees the slot at the same edge, so a full FIFO still accepts.
  assign push_ok = push_i && (!full_o || pop_ok);
  assign drop_o  = push_i && full_o && !pop_ok;
  assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  // Next pointers advance on accepted push/pop, wrapping naturally.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
  end

  // Pointer and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: word RAM with combinational read, byte-lane
// merged stores, sticky error flags and a trace of committed stores.
module dm_responder
  import dm_defs::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int TRACE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DMAdr,
  input  logic        DMcurWE,
  input  logic [1:0]  DMWLen,
  input  logic [31:0] DMDataW,
  input  logic [31:0] DMcurPC,
  output logic [31:0] DMDataR,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  input  logic        trace_ready,
  output logic        trace_ovf,
  output logic        misalign_err,
  output logic        range_err
);
  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(4 * DEPTH_WORDS);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [AW-1:0] widx;
  logic [31:0] old_w, new_w;
  logic        in_range, aligned, commit;
  logic        ovf_q, mis_q, rng_q, ovf_d, mis_d, rng_d;
  logic        fifo_full, fifo_empty, fifo_drop;
  trace_ent_t  push_ent, head_ent;

  assign in_range = ({1'b0, DMAdr} < LIMIT);
  assign widx     = DMAdr[AW+1:2];
  assign old_w    = mem_q[widx];
  assign DMDataR  = in_range ? old_w : '0;
  assign aligned  = store_aligned(DMWLen, DMAdr[1:0]);
  assign commit   = DMcurWE && aligned && in_range;
  assign new_w    = merge_word(old_w, DMDataW, DMWLen, DMAdr[1:0]);

  assign push_ent = '{pc: DMcurPC, addr: {DMAdr[31:2], 2'b00}, data: new_w};

  // RAM: cleared on reset, merged word written on a committed store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (commit) begin
      mem_q[widx] <= new_w;
    end
  end

  // Sticky flag next-state: any out-of-range address is flagged, stores
  // additionally flag misalignment; the two are independent.
  always_comb begin
    rng_d = rng_q | !in_range;
    mis_d = mis_q | (DMcurWE && !aligned);
    ovf_d = ovf_q | fifo_drop;
  end

  // Sticky flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rng_q <= 1'b0;
      mis_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      rng_q <= rng_d;
      mis_q <= mis_d;
      ovf_q <= ovf_d;
    end
  end

  trace_fifo #(
    .W     ($bits(trace_ent_t)),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (commit),
    .pop_i   (trace_ready),
    .din_i   (push_ent),
    .dout_o  (head_ent),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  assign trace_valid  = !fifo_empty;
  assign trace_pc     = head_ent.pc;
  assign trace_addr   = head_ent.addr;
  assign trace_data   = head_ent.data;
  assign trace_ovf    = ovf_q;
  assign misalign_err = mis_q;
  assign range_err    = rng_q;

  // Full status is implied by drop; kept for observability in waves.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_dm_responder.sv
// Randomized + directed bench for dm_responder against a byte-array model.
module tb_dm_responder;
  localparam int DW = 1024;
  localparam int TD = 4;

  logic        clk, reset;
  logic [31:0] DMAdr, DMDataW, DMcurPC, DMDataR;
  logic        DMcurWE, trace_ready;
  logic [1:0]  DMWLen;
  logic        trace_valid, trace_ovf, misalign_err, range_err;
  logic [31:0] trace_pc, trace_addr, trace_data;

  dm_responder #(.DEPTH_WORDS(DW), .TRACE_DEPTH(TD)) dut (
    .clk(clk), .reset(reset), .DMAdr(DMAdr), .DMcurWE(DMcurWE),
    .DMWLen(DMWLen), .DMDataW(DMDataW), .DMcurPC(DMcurPC),
    .DMDataR(DMDataR), .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_addr(trace_addr), .trace_data(trace_data),
    .trace_ready(trace_ready), .trace_ovf(trace_ovf),
    .misalign_err(misalign_err), .range_err(range_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } tent_t;

  logic [7:0]  mb [4*DW];
  tent_t       tq[$];
  logic        m_ovf, m_mis, m_rng;
  int          n_pass, n_tot;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] mread(input logic [31:0] a);
    logic [31:0] b;
    if (a >= 32'(4*DW)) return 32'h0;
    b = a & 32'hFFFF_FFFC;
    return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
  endfunction

  task automatic mreset();
    for (int i = 0; i < 4*DW; i++) mb[i] = 8'h00;
    tq.delete();
    m_ovf = 0; m_mis = 0; m_rng = 0;
  endtask

  // Model of one clock edge given the currently driven inputs.
  task automatic medge(input logic we, input logic [1:0] len, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] pc, input logic rdy);
    int nb;
    bit ok, inr, popped;
    tent_t e;
    nb  = (len == 2'd0) ? 4 : (len == 2'd1) ? 2 : 1;
    ok  = (len != 2'd3) && ((a % nb) == 0);
    inr = (a < 32'(4*DW));
    if (!inr) m_rng = 1;
    if (we && !ok) m_mis = 1;
    popped = rdy && (tq.size() != 0);
    if (popped) void'(tq.pop_front());
    if (we && ok && inr) begin
      for (int k = 0; k < nb; k++) mb[a+k] = d[8*k +: 8];
      e.pc = pc; e.addr = a & 32'hFFFF_FFFC; e.data = mread(a);
      if (tq.size() >= TD) m_ovf = 1;
      else tq.push_back(e);
    end
  endtask

  task automatic check_outs(input logic [31:0] a);
    chk("rdata", DMDataR, mread(a));
    chk("tvalid", 32'(trace_valid), 32'(tq.size() != 0));
    if (tq.size() != 0) begin
      chk("tpc", trace_pc, tq[0].pc);
      chk("taddr", trace_addr, tq[0].addr);
      chk("tdata", trace_data, tq[0].data);
    end
    chk("ovf", 32'(trace_ovf), 32'(m_ovf));
    chk("mis", 32'(misalign_err), 32'(m_mis));
    chk("rng", 32'(range_err), 32'(m_rng));
  endtask

  task automatic step(input logic we, input logic [1:0] len, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] pc, input logic rdy);
    @(negedge clk);
    DMcurWE = we; DMWLen = len; DMAdr = a; DMDataW = d; DMcurPC = pc; trace_ready = rdy;
    #1;
    check_outs(a);
    @(posedge clk);
    medge(we, len, a, d, pc, rdy);
  endtask

  task automatic rd(input logic [31:0] a, input logic rdy);
    step(1'b0, 2'd0, a, 32'h0, 32'h0, rdy);
  endtask

  initial begin
    logic [31:0] ra, rdat;
    n_pass = 0; n_tot = 0;
    reset = 0; DMcurWE = 0; DMWLen = 0; DMAdr = 0; DMDataW = 0; DMcurPC = 0; trace_ready = 0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(trace_valid), 32'h0);
    chk("rst_tpc", trace_pc, 32'h0);
    chk("rst_tdata", trace_data, 32'h0);
    chk("rst_flags", {29'h0, trace_ovf, misalign_err, range_err}, 32'h0);
    @(negedge clk); reset = 1;

    // Word store then readback and trace head.
    rd(32'h10, 0);
    step(1, 2'd0, 32'h10, 32'h1122_3344, 32'h100, 0);
    rd(32'h10, 0);
    chk("sw_word", mread(32'h10), 32'h1122_3344);
    // Byte then half merges on the same word.
    step(1, 2'd2, 32'h12, 32'h0000_00AB, 32'h104, 0);
    step(1, 2'd1, 32'h10, 32'h0000_BEEF, 32'h108, 0);
    rd(32'h10, 1);
    rd(32'h10, 1);
    rd(32'h10, 1);
    chk("merge_word", mread(32'h10), 32'h11AB_BEEF);
    // Misaligned and reserved-width stores.
    step(1, 2'd1, 32'h11, 32'h0000_5555, 32'h10C, 0);
    step(1, 2'd0, 32'h12, 32'h6666_6666, 32'h110, 0);
    step(1, 2'd3, 32'h10, 32'h7777_7777, 32'h114, 0);
    rd(32'h10, 0);
    // Out-of-range store.
    step(1, 2'd0, 32'h1000, 32'hDEAD_BEEF, 32'h118, 0);
    rd(32'h1000, 0);
    rd(32'h20, 0);
    // Overflow: five stores, none popped.
    for (int i = 0; i < 5; i++)
      step(1, 2'd0, 32'h40 + 32'(4*i), 32'hA000_0000 + 32'(i), 32'h200 + 32'(4*i), 0);
    for (int i = 0; i < 5; i++) rd(32'h40 + 32'(4*i), 0);
    for (int i = 0; i < 5; i++) rd(32'h40, 1);
    // Refill, then push and pop together while full.
    for (int i = 0; i < 4; i++)
      step(1, 2'd2, 32'h60 + 32'(i), 32'h0000_00C0 + 32'(i), 32'h300 + 32'(4*i), 0);
    for (int i = 0; i < 3; i++)
      step(1, 2'd1, 32'h70 + 32'(2*i), 32'h0000_D000 + 32'(i), 32'h340 + 32'(4*i), 1);
    for (int i = 0; i < 5; i++) rd(32'h60, 1);

    // Asynchronous reset between edges during a store.
    @(negedge clk);
    DMcurWE = 1; DMWLen = 2'd0; DMAdr = 32'h40; DMDataW = 32'h5A5A_5A5A; DMcurPC = 32'h400;
    trace_ready = 0;
    #2 reset = 0;
    #1;
    mreset();
    chk("arst_rdata", DMDataR, 32'h0);
    chk("arst_valid", 32'(trace_valid), 32'h0);
    chk("arst_tdata", trace_data, 32'h0);
    chk("arst_flags", {29'h0, trace_ovf, misalign_err, range_err}, 32'h0);
    DMcurWE = 0;
    @(negedge clk); reset = 1;
    rd(32'h40, 0);
    rd(32'h10, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 4) ra = 32'h1000 + ($urandom & 32'hFF);
      else ra = 32'($urandom_range(0, 63));
      rdat = $urandom;
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, rdat, $urandom,
           ($urandom_range(0, 2) == 0));
    end
    for (int i = 0; i < 6; i++) rd(32'($urandom_range(0, 15)) * 4, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
